mmio_uart_rx: RTL and testbench
===============================

Name: mmio_uart_rx

Overview:
- Memory-mapped UART receiver; receive-side counterpart of the MMIO UART transmitter on the same MMIO bus.
- Oversamples the serial input, deframes 8N1 bytes into a FIFO, and exposes data and status registers on a 32-bit MMIO request/response port.
- Sits on the MMIO address decoder next to the transmitter. The CPU polls STATUS and pops bytes from DATA.

Parameters:
- FMAX_MHz, 27, core clock frequency in MHz.
- BAUD, 115200, line rate. CLKS_PER_BIT = FMAX_MHz*1_000_000/BAUD, floored; 234 at defaults. Must be >= 4.
- WIDTH, 4, FIFO address bits; depth = 2**WIDTH = 16.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- uart_rx  in  1  serial input, idle high, asynchronous to clk
- req_ready  out  1  request accept
- req_valid  in  1  request valid
- req_addr  in  32  byte address; only bit 2 decoded (0 = DATA, 1 = STATUS)
- req_wen  in  1  1 = write
- req_wdata  in  32  write data
- resp_valid  out  1  response valid
- resp_rdata  out  32  read data

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - req_ready=0 while rst_n low, 1 afterwards.
  - resp_valid=0, resp_rdata=0.
  - FIFO empty; sticky flags 0; FSM in IDLE.
  - Synchronizer flops reset to 1.
- Input path: 2-flop synchronizer on uart_rx (rxs). All FSM decisions use rxs.
- FSM states and transitions:
  - IDLE: when rxs==0, clear the baud counter and go to START.
  - START: count CLKS_PER_BIT/2 cycles, then sample.
    - rxs==0: go to DATA with bit index 0 and counter cleared.
    - rxs==1 (glitch): return to IDLE, no flag set.
  - DATA: every CLKS_PER_BIT cycles, sample rxs into shift bit [index], LSB first. After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample.
    - rxs==1: push the byte and go to IDLE.
    - rxs==0: set frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rxs==1, then go to IDLE.
- FIFO push:
  - Push when a byte is accepted in STOP.
  - If the FIFO is full and no pop occurs in the same cycle: drop the byte and set overrun (sticky).
  - Full with a simultaneous pop: the push succeeds and count is unchanged.
  - Read/write pointers wrap modulo depth. count is WIDTH+1 bits, range 0..depth.
- MMIO handshake:
  - req_ready is 1 every cycle after reset; no backpressure.
  - A request is accepted when req_valid && req_ready.
  - resp_valid pulses high exactly 1 cycle after each accepted request, reads and writes alike.
  - resp_rdata is meaningful only while resp_valid is high; 0 otherwise.
- Read DATA (addr bit2=0):
  - rdata = {23'b0, nonempty, head_byte}.
  - If nonempty, pop the head in the acceptance cycle.
  - If empty, return 0 and pop nothing. A byte pushed in that same cycle is not returned; it stays in the FIFO.
- Read STATUS (addr bit2=1): rdata = {16'b0, 6'b0, overrun, frame_err, 3'b0, count}, with count occupying bits [WIDTH:0]. Reads have no side effect.
- Write STATUS: wdata bit9=1 clears overrun; wdata bit8=1 clears frame_err.
  - A clear in the same cycle as a new set: set wins.
- Write DATA: ignored, responds with rdata 0.
- Reset mid-frame: FSM returns to IDLE and the partial byte is lost. After rst_n rises, the FSM waits for a falling edge before starting a new frame.
- Latency: a byte is visible in count 1 cycle after the STOP sample. Worst case from the stop-bit midpoint is 3 cycles (2 synchronizer cycles + 1).

Test Plan (FMAX_MHz=1, BAUD=100000 -> CLKS_PER_BIT=10; WIDTH=2 -> depth 4):
- Send 0xA5 framed 8N1 at 10 clk/bit, then read STATUS -> rdata=0x00000001. Read DATA -> resp_valid next cycle with rdata=0x000001A5. Read STATUS -> 0x00000000.
- Read DATA while the FIFO is empty -> rdata=0x00000000 and count stays 0.
- 3-cycle low pulse on uart_rx -> no byte, frame_err=0, FSM back in IDLE. Then send 0x3C -> received correctly.
- Send 0x55 with the stop bit held low for 30 cycles, then high -> STATUS=0x00000100, FIFO empty. Write STATUS wdata=0x100 -> STATUS=0x00000000.
- Send 5 bytes 0x01..0x05 with no reads:
  - STATUS=0x00000204 (overrun=1, count=4).
  - DATA reads return 0x101, 0x102, 0x103, 0x104, then 0x000.
- Assert rst_n low during bit 4 of a frame, release, then send 0x7E -> only 0x7E is in the FIFO and STATUS=0x00000001.

Source files
------------

// File: rtl/mmio_uart_rx.sv
// MMIO UART receiver: oversampled 8N1 deframer feeding a byte FIFO, with
// DATA (pop head) and STATUS (flags + count) registers on a 32-bit MMIO port.
module mmio_uart_rx #(
    parameter int FMAX_MHz = 27,
    parameter int BAUD     = 115200,
    parameter int WIDTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        req_ready,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata
);
    localparam int CLKS_PER_BIT = FMAX_MHz * 1_000_000 / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int DEPTH        = 2 ** WIDTH;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_rx_meta;
    logic               r_rxs;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_next;
    logic               w_half;
    logic               w_bit_end;
    logic               w_cnt_clr;
    logic               w_sample_bit;
    logic               w_byte_done;
    logic               w_frame_err_set;

    logic [7:0]         r_mem [DEPTH];
    logic [WIDTH-1:0]   r_wptr;
    logic [WIDTH-1:0]   r_rptr;
    logic [WIDTH:0]     r_count;
    logic               r_overrun;
    logic               r_frame_err;
    logic               r_ready;
    logic               r_resp_valid;
    logic [31:0]        r_resp_rdata;

    logic               w_accept;
    logic               w_rd_data;
    logic               w_rd_status;
    logic               w_wr_status;
    logic               w_nonempty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_overrun_set;
    logic [31:0]        w_status;
    logic [31:0]        w_resp_next;
    logic               w_unused;

    assign w_unused = &{1'b0, req_addr[31:3], req_addr[1:0],
                        req_wdata[31:10], req_wdata[7:0]};

    // Two-flop synchronizer; resets to idle-high so a released reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rxs     <= r_rx_meta;
        end
    end

    assign w_half    = (r_cnt == CW'(HALF_BIT - 1));
    assign w_bit_end = (r_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (!r_rxs) w_state_next = S_START;
            S_START: if (w_half) w_state_next = r_rxs ? S_IDLE : S_DATA;
            S_DATA:  if (w_bit_end && (r_idx == 3'd7)) w_state_next = S_STOP;
            S_STOP:  if (w_bit_end) w_state_next = r_rxs ? S_IDLE : S_BREAK;
            S_BREAK: if (r_rxs) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_clr       = 1'b0;
        w_sample_bit    = 1'b0;
        w_byte_done     = 1'b0;
        w_frame_err_set = 1'b0;
        case (r_state)
            S_IDLE:  w_cnt_clr = 1'b1;
            S_START: w_cnt_clr = w_half;
            S_DATA: begin
                w_cnt_clr    = w_bit_end;
                w_sample_bit = w_bit_end;
            end
            S_STOP: begin
                w_cnt_clr       = w_bit_end;
                w_byte_done     = w_bit_end && r_rxs;
                w_frame_err_set = w_bit_end && !r_rxs;
            end
            S_BREAK: w_cnt_clr = 1'b1;
            default: w_cnt_clr = 1'b1;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_shift
            assign w_shift_next[gi] = (w_sample_bit && (r_idx == 3'(gi))) ? r_rxs : r_shift[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_cnt   <= w_cnt_clr ? '0 : r_cnt + CW'(1);
            r_idx   <= (r_state == S_DATA) ? (w_sample_bit ? r_idx + 3'd1 : r_idx) : 3'd0;
            r_shift <= w_shift_next;
        end
    end

    assign w_accept      = req_valid && r_ready;
    assign w_rd_data     = w_accept && !req_wen && !req_addr[2];
    assign w_rd_status   = w_accept && !req_wen && req_addr[2];
    assign w_wr_status   = w_accept && req_wen && req_addr[2];
    assign w_nonempty    = (r_count != '0);
    assign w_full        = (r_count == (WIDTH+1)'(DEPTH));
    assign w_pop         = w_rd_data && w_nonempty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
    assign w_push        = w_byte_done && (!w_full || w_pop);
    assign w_overrun_set = w_byte_done && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= r_shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + WIDTH'(1);
            if (w_pop)  r_rptr <= r_rptr + WIDTH'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (WIDTH+1)'(1);
                2'b01:   r_count <= r_count - (WIDTH+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as a software clear takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_overrun_set)                     r_overrun <= 1'b1;
            else if (w_wr_status && req_wdata[9])  r_overrun <= 1'b0;
            if (w_frame_err_set)                   r_frame_err <= 1'b1;
            else if (w_wr_status && req_wdata[8])  r_frame_err <= 1'b0;
        end
    end

    always_comb begin
        w_status          = '0;
        w_status[9]       = r_overrun;
        w_status[8]       = r_frame_err;
        w_status[WIDTH:0] = r_count;
    end

    always_comb begin
        w_resp_next = '0;
        if (w_rd_data && w_nonempty) w_resp_next = {23'b0, 1'b1, r_mem[r_rptr]};
        else if (w_rd_status)        w_resp_next = w_status;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_ready      <= 1'b1;
            r_resp_valid <= w_accept;
            r_resp_rdata <= w_resp_next;
        end
    end

    assign req_ready  = r_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_mmio_uart_rx.sv
// Scoreboard bench for mmio_uart_rx: directed serial frames and MMIO accesses,
// expected responses queued at issue time and checked by an independent monitor.
module tb_mmio_uart_rx;
    localparam int CPB = 10;
    localparam logic [31:0] A_DATA   = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        uart_rx;
    logic        req_ready;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    typedef struct {
        logic [31:0] exp;
        bit          chk;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    mmio_uart_rx #(.FMAX_MHz(1), .BAUD(100000), .WIDTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .req_ready  (req_ready),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_wen    (req_wen),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h, required %08h", name, got, exp);
        end else begin
            $display("ok   %s: %08h", name, got);
        end
    endtask

    // Monitor: pops one expectation for every response the DUT presents
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_resp: got %08h, required no response", resp_rdata);
            end else begin
                mon_e = q.pop_front();
                if (mon_e.chk) begin
                    n_vec++;
                    if (resp_rdata !== mon_e.exp) begin
                        n_miss++;
                        $display("FAIL %s: got %08h, required %08h", mon_e.name, resp_rdata, mon_e.exp);
                    end else begin
                        $display("ok   %s: %08h", mon_e.name, resp_rdata);
                    end
                end else begin
                    $display("resp %s: %08h (unchecked)", mon_e.name, resp_rdata);
                end
            end
        end
    end

    task automatic mmio(input logic [31:0] addr, input bit wen, input logic [31:0] wdata,
                        input logic [31:0] exp, input bit chk, input string name);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = addr;
        req_wen   = wen;
        req_wdata = wdata;
        q.push_back('{exp, chk, name});
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_wdata = '0;
        @(negedge clk);
        check({name, "_resp_valid"}, {31'b0, resp_valid}, 32'h1);
    endtask

    task automatic uart_bit(input logic v);
        uart_rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int stop_low);
        @(posedge clk); #1;
        uart_bit(1'b0);
        for (int i = 0; i < 8; i++) uart_bit(b[i]);
        if (stop_low > 0) begin
            uart_rx = 1'b0;
            repeat (stop_low) @(posedge clk);
            #1;
        end
        uart_bit(1'b1);
        repeat (5) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        uart_rx   = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wen   = 1'b0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'h0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("ready_after_rst", {31'b0, req_ready}, 32'h1);
        mmio(A_STATUS, 1'b0, 32'h0, 32'h0, 1'b1, "status_reset");

        // Basic byte
        send_byte(8'hA5, 0);
        mmio(A_STATUS, 1'b0, 32'h0, 32'h0000_0001, 1'b1, "status_a5");
        mmio(A_DATA,   1'b0, 32'h0, 32'h0000_01A5, 1'b1, "data_a5");
        mmio(A_STATUS, 1'b0, 32'h0, 32'h0000_0000, 1'b1, "status_after_a5");

        // Empty read
        mmio(A_DATA,   1'b0, 32'h0, 32'h0000_0000, 1'b1, "data_empty");
        mmio(A_STATUS, 1'b0, 32'h0, 32'h0000_0000, 1'b1, "status_empty");

        // Glitch rejection, then a clean frame
        @(posedge clk); #1;
        uart_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (30) @(posedge clk);
        mmio(A_STATUS, 1'b0, 32'h0, 32'h0000_0000, 1'b1, "status_glitch");
        send_byte(8'h3C, 0);
        mmio(A_DATA,   1'b0, 32'h0, 32'h0000_013C, 1'b1, "data_3c");

        // Framing error with long low stop bit
        send_byte(8'h55, 30);
        mmio(A_STATUS, 1'b0, 32'h0,   32'h0000_0100, 1'b1, "status_frame_err");
        mmio(A_STATUS, 1'b1, 32'h100, 32'h0,         1'b0, "clear_frame_err");
        mmio(A_STATUS, 1'b0, 32'h0,   32'h0000_0000, 1'b1, "status_fe_cleared");

        // Overrun: five bytes into a depth-4 FIFO
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 0);
        mmio(A_STATUS, 1'b0, 32'h0, 32'h0000_0204, 1'b1, "status_overrun");
        mmio(A_DATA,   1'b0, 32'h0, 32'h0000_0101, 1'b1, "data_01");
        mmio(A_DATA,   1'b0, 32'h0, 32'h0000_0102, 1'b1, "data_02");
        mmio(A_DATA,   1'b0, 32'h0, 32'h0000_0103, 1'b1, "data_03");
        mmio(A_DATA,   1'b0, 32'h0, 32'h0000_0104, 1'b1, "data_04");
        mmio(A_DATA,   1'b0, 32'h0, 32'h0000_0000, 1'b1, "data_drained");
        mmio(A_STATUS, 1'b0, 32'h0, 32'h0000_0200, 1'b1, "status_ov_sticky");
        mmio(A_STATUS, 1'b1, 32'h200, 32'h0,       1'b0, "clear_overrun");
        mmio(A_STATUS, 1'b0, 32'h0, 32'h0000_0000, 1'b1, "status_ov_cleared");

        // Write to DATA is ignored
        mmio(A_DATA,   1'b1, 32'hFF, 32'h0000_0000, 1'b1, "write_data");
        mmio(A_STATUS, 1'b0, 32'h0,  32'h0000_0000, 1'b1, "status_after_wr");

        // Reset during bit 4 of a frame
        @(posedge clk); #1;
        uart_bit(1'b0);
        for (int i = 0; i < 4; i++) uart_bit(1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        @(negedge clk);
        check("midrst_req_ready", {31'b0, req_ready}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        send_byte(8'h7E, 0);
        mmio(A_STATUS, 1'b0, 32'h0, 32'h0000_0001, 1'b1, "status_7e");
        mmio(A_DATA,   1'b0, 32'h0, 32'h0000_017E, 1'b1, "data_7e");
        mmio(A_STATUS, 1'b0, 32'h0, 32'h0000_0000, 1'b1, "status_final");

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL missing_resp: %0d responses outstanding, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
